// File: rtl/wb_exc_commit_pkg.sv
// Shared constants for the write-back / exception-commit stage: exception
// codes, the ex_flags bit order and the MEM->WB bus width helper.
// Optional feature macro used by the top: WB_DEBUG_TRACE_EN.
package wb_exc_commit_pkg;

    // Bit positions inside ms_ex_flags = {int,adef,ine,sys,brk,ale}
    localparam int EX_FLAGS_W = 6;
    localparam int EX_BIT_INT  = 5;
    localparam int EX_BIT_ADEF = 4;
    localparam int EX_BIT_INE  = 3;
    localparam int EX_BIT_SYS  = 2;
    localparam int EX_BIT_BRK  = 1;
    localparam int EX_BIT_ALE  = 0;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    // Result of the priority encoder
    typedef struct packed {
        logic       ex;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } exc_info_t;

    // MEM->WB bus: pc, result, vaddr, csr_wvalue, csr_wmask (5 x dw), dest,
    // csr_num, plus rf_we, csr_re, csr_we, ertn and the 6 flags.
    function automatic int ms_to_ws_bus_w(input int dw, input int rw, input int csrn_w);
        return 5 * dw + rw + csrn_w + 4 + EX_FLAGS_W;
    endfunction

endpackage

// File: rtl/wb_exc_commit_exc_prio_enc.sv
// Combinational exception priority encoder: int > adef > ine > sys > brk > ale.
module exc_prio_enc
    import wb_exc_commit_pkg::*;
(
    input  logic [EX_FLAGS_W-1:0] flags,
    output exc_info_t             info
);

    // Pick the highest-priority flag; esubcode is only non-default for ADEF
    always_comb begin
        info.ex       = |flags;
        info.ecode    = ECODE_INT;
        info.esubcode = ESUBCODE_NONE;
        if (flags[EX_BIT_INT]) begin
            info.ecode = ECODE_INT;
        end else if (flags[EX_BIT_ADEF]) begin
            info.ecode    = ECODE_ADE;
            info.esubcode = ESUBCODE_ADEF;
        end else if (flags[EX_BIT_INE]) begin
            info.ecode = ECODE_INE;
        end else if (flags[EX_BIT_SYS]) begin
            info.ecode = ECODE_SYS;
        end else if (flags[EX_BIT_BRK]) begin
            info.ecode = ECODE_BRK;
        end else if (flags[EX_BIT_ALE]) begin
            info.ecode = ECODE_ALE;
        end
    end

endmodule

// File: rtl/wb_exc_commit.sv
// Write-back stage: MEM->WB pipeline register, exception commit, CSR and
// regfile write drive, one-cycle flush with redirect PC.
// Optional macro WB_DEBUG_TRACE_EN adds the debug_wb_* trace outputs.
//
// Handshake: an instruction moves MEM->WB on a rising edge where
// ms_to_ws_valid && ws_allowin; WB always finishes in one cycle
// (ws_ready_go=1), so ws_allowin is asserted whenever WB is empty or done.
module wb_exc_commit
    import wb_exc_commit_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RW     = 5,
    parameter int CSRN_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ms_to_ws_valid,
    output logic                  ws_allowin,
    input  logic [DW-1:0]         ms_pc,
    input  logic [DW-1:0]         ms_result,
    input  logic [DW-1:0]         ms_vaddr,
    input  logic [RW-1:0]         ms_dest,
    input  logic                  ms_rf_we,
    input  logic                  ms_csr_re,
    input  logic                  ms_csr_we,
    input  logic [CSRN_W-1:0]     ms_csr_num,
    input  logic [DW-1:0]         ms_csr_wvalue,
    input  logic [DW-1:0]         ms_csr_wmask,
    input  logic [EX_FLAGS_W-1:0] ms_ex_flags,
    input  logic                  ms_ertn,
    input  logic [DW-1:0]         csr_rvalue,
    input  logic [DW-1:0]         csr_eentry,
    input  logic [DW-1:0]         csr_era,
    output logic                  wb_ex,
    output logic [5:0]            wb_ecode,
    output logic [8:0]            wb_esubcode,
    output logic [DW-1:0]         wb_pc,
    output logic [DW-1:0]         wb_vaddr,
    output logic                  ertn_flush,
    output logic                  csr_re,
    output logic                  csr_we,
    output logic [CSRN_W-1:0]     csr_num,
    output logic [DW-1:0]         csr_wvalue,
    output logic [DW-1:0]         csr_wmask,
    output logic                  rf_we,
    output logic [RW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    output logic                  flush,
    output logic [DW-1:0]         flush_pc
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [DW-1:0]         debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [RW-1:0]         debug_wb_rf_wnum,
    output logic [DW-1:0]         debug_wb_rf_wdata
`endif
);

    localparam int BUS_W = ms_to_ws_bus_w(DW, RW, CSRN_W);

    logic             ws_valid;
    logic             ws_ready_go;
    logic             commit;
    logic [BUS_W-1:0] ms_bus;
    logic [BUS_W-1:0] ws_bus;

    logic [DW-1:0]         ws_pc;
    logic [DW-1:0]         ws_result;
    logic [DW-1:0]         ws_vaddr;
    logic [RW-1:0]         ws_dest;
    logic                  ws_rf_we;
    logic                  ws_csr_re;
    logic                  ws_csr_we;
    logic [CSRN_W-1:0]     ws_csr_num;
    logic [DW-1:0]         ws_csr_wvalue;
    logic [DW-1:0]         ws_csr_wmask;
    logic [EX_FLAGS_W-1:0] ws_ex_flags;
    logic                  ws_ertn;
    exc_info_t             exc;

    assign ms_bus = {ms_pc, ms_result, ms_vaddr, ms_dest, ms_rf_we, ms_csr_re, ms_csr_we,
                     ms_csr_num, ms_csr_wvalue, ms_csr_wmask, ms_ex_flags, ms_ertn};
    assign {ws_pc, ws_result, ws_vaddr, ws_dest, ws_rf_we, ws_csr_re, ws_csr_we,
            ws_csr_num, ws_csr_wvalue, ws_csr_wmask, ws_ex_flags, ws_ertn} = ws_bus;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // Valid bit: cleared by reset and by a flush (the incoming instruction is younger)
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    // Payload capture on an accepted transfer; contents are don't-care while invalid
    always_ff @(posedge clk) begin
        if (ws_allowin && ms_to_ws_valid) begin
            ws_bus <= ms_bus;
        end
    end

    exc_prio_enc u_exc_prio_enc (
        .flags (ws_ex_flags),
        .info  (exc)
    );

    // A commit in the cycle reset is asserted must not write CSR or regfile state
    assign commit = ws_valid && !reset;

    assign wb_ex       = commit && exc.ex;
    assign wb_ecode    = exc.ecode;
    assign wb_esubcode = exc.esubcode;
    assign wb_pc       = ws_pc;
    assign wb_vaddr    = ws_vaddr;
    assign ertn_flush  = commit && ws_ertn && !wb_ex;
    assign flush       = wb_ex || ertn_flush;
    assign flush_pc    = wb_ex ? csr_eentry : csr_era;

    assign csr_re     = commit && ws_csr_re && !exc.ex;
    assign csr_we     = commit && ws_csr_we && !exc.ex;
    assign csr_num    = ws_csr_num;
    assign csr_wvalue = ws_csr_wvalue;
    assign csr_wmask  = ws_csr_wmask;

    assign rf_we    = commit && ws_rf_we && !exc.ex && !ws_ertn && (ws_dest != '0);
    assign rf_waddr = ws_dest;
    assign rf_wdata = csr_re ? csr_rvalue : ws_result;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Directed testbench for wb_exc_commit.
module tb_wb_exc_commit;

    localparam int DW     = 32;
    localparam int RW     = 5;
    localparam int CSRN_W = 14;

    logic              clk;
    logic              reset;
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [DW-1:0]     ms_pc, ms_result, ms_vaddr;
    logic [RW-1:0]     ms_dest;
    logic              ms_rf_we, ms_csr_re, ms_csr_we;
    logic [CSRN_W-1:0] ms_csr_num;
    logic [DW-1:0]     ms_csr_wvalue, ms_csr_wmask;
    logic [5:0]        ms_ex_flags;
    logic              ms_ertn;
    logic [DW-1:0]     csr_rvalue, csr_eentry, csr_era;
    logic              wb_ex;
    logic [5:0]        wb_ecode;
    logic [8:0]        wb_esubcode;
    logic [DW-1:0]     wb_pc, wb_vaddr;
    logic              ertn_flush, csr_re, csr_we;
    logic [CSRN_W-1:0] csr_num;
    logic [DW-1:0]     csr_wvalue, csr_wmask;
    logic              rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              flush;
    logic [DW-1:0]     flush_pc;
`ifdef WB_DEBUG_TRACE_EN
    logic [DW-1:0]     debug_wb_pc;
    logic [3:0]        debug_wb_rf_we;
    logic [RW-1:0]     debug_wb_rf_wnum;
    logic [DW-1:0]     debug_wb_rf_wdata;
`endif

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected regfile writes {waddr, wdata}
    logic [RW+DW-1:0] exp_q[$];

    wb_exc_commit #(.DW(DW), .RW(RW), .CSRN_W(CSRN_W)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_vaddr(ms_vaddr), .ms_dest(ms_dest),
        .ms_rf_we(ms_rf_we), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
        .ms_csr_num(ms_csr_num), .ms_csr_wvalue(ms_csr_wvalue), .ms_csr_wmask(ms_csr_wmask),
        .ms_ex_flags(ms_ex_flags), .ms_ertn(ms_ertn),
        .csr_rvalue(csr_rvalue), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: every regfile write must match the next expected one
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rf_unexpected", 64'({rf_waddr, rf_wdata}), 64'h0);
            end else begin
                check("rf_sb", 64'({rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_ms();
        ms_pc = '0; ms_result = '0; ms_vaddr = '0; ms_dest = '0;
        ms_rf_we = 1'b0; ms_csr_re = 1'b0; ms_csr_we = 1'b0; ms_csr_num = '0;
        ms_csr_wvalue = '0; ms_csr_wmask = '0; ms_ex_flags = '0; ms_ertn = 1'b0;
    endtask

    // One idle cycle, then present the ms_* bus for one accept edge; returns
    // #1 into the commit cycle with the input side idle again.
    task automatic send();
        ms_to_ws_valid = 1'b0;
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b1;
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
    endtask

    logic [5:0] ecode_tab [6];

    initial begin
        ecode_tab[5] = 6'h00; ecode_tab[4] = 6'h08; ecode_tab[3] = 6'h0D;
        ecode_tab[2] = 6'h0B; ecode_tab[1] = 6'h0C; ecode_tab[0] = 6'h09;

        clear_ms();
        csr_rvalue = '0; csr_eentry = '0; csr_era = '0;

        // 1. reset held 3 cycles with valid input
        reset = 1'b1;
        ms_to_ws_valid = 1'b1;
        ms_rf_we = 1'b1; ms_dest = 5'd9; ms_ex_flags = 6'b000100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_ex", 64'(wb_ex), 64'h0);
        check("rst_ertn_flush", 64'(ertn_flush), 64'h0);
        check("rst_csr_we", 64'(csr_we), 64'h0);
        check("rst_csr_re", 64'(csr_re), 64'h0);
        check("rst_rf_we", 64'(rf_we), 64'h0);
        check("rst_flush", 64'(flush), 64'h0);
        check("rst_allowin", 64'(ws_allowin), 64'h1);
        ms_to_ws_valid = 1'b0;
        reset = 1'b0;
        clear_ms();

        // 2. plain add
        ms_pc = 32'h1c000010; ms_dest = 5'd5; ms_result = 32'd7; ms_rf_we = 1'b1;
        exp_q.push_back({5'd5, 32'd7});
        send();
        #1;
        check("add_rf_we", 64'(rf_we), 64'h1);
        check("add_waddr", 64'(rf_waddr), 64'h5);
        check("add_wdata", 64'(rf_wdata), 64'h7);
        check("add_flush", 64'(flush), 64'h0);
        check("add_wb_ex", 64'(wb_ex), 64'h0);

        // 3. adef+ine -> ADE
        clear_ms();
        ms_pc = 32'h1c000020; ms_ex_flags = 6'b011000; ms_rf_we = 1'b1; ms_dest = 5'd6;
        csr_eentry = 32'h1c008000; csr_era = 32'h1c000abc;
        send();
        #1;
        check("adef_wb_ex", 64'(wb_ex), 64'h1);
        check("adef_ecode", 64'(wb_ecode), 64'h8);
        check("adef_esub", 64'(wb_esubcode), 64'h0);
        check("adef_wb_pc", 64'(wb_pc), 64'h1c000020);
        check("adef_flush", 64'(flush), 64'h1);
        check("adef_flush_pc", 64'(flush_pc), 64'h1c008000);
        check("adef_rf_we", 64'(rf_we), 64'h0);

        // 4. int+ale; a younger instruction arriving in the flush cycle is dropped
        clear_ms();
        ms_pc = 32'h1c000030; ms_ex_flags = 6'b100001; ms_vaddr = 32'h3;
        send();
        clear_ms();
        ms_rf_we = 1'b1; ms_dest = 5'd7; ms_result = 32'h99;
        ms_to_ws_valid = 1'b1;
        #1;
        check("int_ecode", 64'(wb_ecode), 64'h0);
        check("int_wb_ex", 64'(wb_ex), 64'h1);
        check("int_vaddr", 64'(wb_vaddr), 64'h3);
        check("int_allowin", 64'(ws_allowin), 64'h1);
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
        check("drop_rf_we", 64'(rf_we), 64'h0);
        check("drop_flush", 64'(flush), 64'h0);
        check("drop_wb_ex", 64'(wb_ex), 64'h0);

        // 5. ertn
        clear_ms();
        ms_ertn = 1'b1; ms_rf_we = 1'b1; ms_dest = 5'd3;
        csr_era = 32'h1c000100; csr_eentry = 32'h1c008000;
        send();
        #1;
        check("ertn_flush_o", 64'(ertn_flush), 64'h1);
        check("ertn_flush", 64'(flush), 64'h1);
        check("ertn_flush_pc", 64'(flush_pc), 64'h1c000100);
        check("ertn_csr_we", 64'(csr_we), 64'h0);
        check("ertn_rf_we", 64'(rf_we), 64'h0);
        check("ertn_wb_ex", 64'(wb_ex), 64'h0);

        // 6a. csrwr: old value returns through csr_rvalue
        clear_ms();
        ms_csr_re = 1'b1; ms_csr_we = 1'b1; ms_csr_num = 14'h30;
        ms_csr_wvalue = 32'hA5; ms_csr_wmask = 32'hffffffff;
        ms_dest = 5'd4; ms_rf_we = 1'b1; ms_result = 32'hdead;
        exp_q.push_back({5'd4, 32'h11});
        send();
        csr_rvalue = 32'h11;
        #1;
        check("csrwr_csr_we", 64'(csr_we), 64'h1);
        check("csrwr_csr_re", 64'(csr_re), 64'h1);
        check("csrwr_num", 64'(csr_num), 64'h30);
        check("csrwr_wvalue", 64'(csr_wvalue), 64'hA5);
        check("csrwr_wmask", 64'(csr_wmask), 64'hffffffff);
        check("csrwr_wdata", 64'(rf_wdata), 64'h11);
        check("csrwr_flush", 64'(flush), 64'h0);

        // 6b. same with sys flag: all writes suppressed
        ms_ex_flags = 6'b000100;
        send();
        #1;
        check("csrsys_csr_we", 64'(csr_we), 64'h0);
        check("csrsys_csr_re", 64'(csr_re), 64'h0);
        check("csrsys_rf_we", 64'(rf_we), 64'h0);
        check("csrsys_ecode", 64'(wb_ecode), 64'hB);

        // Single-flag ecode table
        for (int i = 0; i < 6; i++) begin
            clear_ms();
            ms_ex_flags = 6'(1 << i);
            send();
            #1;
            check("single_ecode", 64'(wb_ecode), 64'(ecode_tab[i]));
            check("single_flush", 64'(flush), 64'h1);
        end

        // Exception + ertn: exception wins, redirect to EENTRY
        clear_ms();
        ms_ex_flags = 6'b000010; ms_ertn = 1'b1;
        csr_eentry = 32'h1c00f000; csr_era = 32'h1c000200;
        send();
        #1;
        check("exertn_wb_ex", 64'(wb_ex), 64'h1);
        check("exertn_ertn_flush", 64'(ertn_flush), 64'h0);
        check("exertn_ecode", 64'(wb_ecode), 64'hC);
        check("exertn_flush_pc", 64'(flush_pc), 64'h1c00f000);

        // Flush is a one-cycle pulse
        @(posedge clk); #1;
        check("pulse_flush", 64'(flush), 64'h0);

        // dest == 0 never writes
        clear_ms();
        ms_rf_we = 1'b1; ms_dest = 5'd0; ms_result = 32'h55;
        send();
        #1;
        check("r0_rf_we", 64'(rf_we), 64'h0);

        // Reset mid-commit: no CSR/regfile write
        clear_ms();
        ms_rf_we = 1'b1; ms_dest = 5'd8; ms_csr_we = 1'b1; ms_result = 32'h77;
        send();
        reset = 1'b1;
        #1;
        check("rstmid_rf_we", 64'(rf_we), 64'h0);
        check("rstmid_csr_we", 64'(csr_we), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid_after_rf_we", 64'(rf_we), 64'h0);

        @(posedge clk); #1;
        check("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
